// File: rtl/checker_memory_arbiter.sv
// Round-robin two-requester controller for port A of the checker's byte-lane memory.
// Optional macro CHECKER_MEM_ARB_LOCK_EN adds m0_lock/m1_lock for atomic read-modify-write.
module checker_memory_arbiter (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
`ifdef CHECKER_MEM_ARB_LOCK_EN
    input  logic        m0_lock,
    input  logic        m1_lock,
`endif
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_sel,
    input  logic [11:0] m0_adr,
    input  logic [31:0] m0_dat_w,
    output logic        m0_ack,
    output logic [31:0] m0_dat_r,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_sel,
    input  logic [11:0] m1_adr,
    input  logic [31:0] m1_dat_w,
    output logic        m1_ack,
    output logic [31:0] m1_dat_r,
    output logic [15:0] mem_adr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_di,
    input  logic [31:0] mem_do
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RWAIT,
        S_ACK
    } state_t;

    state_t      r_state;
    logic        r_ptr;
    logic        r_gnt;
    logic [3:0]  r_mask;

    logic [1:0]  w_req;
    logic        w_gnt;
    logic        w_we;
    logic [3:0]  w_sel;
    logic [11:0] w_adr;
    logic [31:0] w_dat;
    logic [3:0]  w_sel_low;
    logic [3:0]  w_mask_low;
    logic        w_ptr_hold;

    function automatic logic [3:0] lowest_bit(input logic [3:0] mask);
        return mask & (~mask + 4'd1);
    endfunction

`ifdef CHECKER_MEM_ARB_LOCK_EN
    logic r_locked;
    logic r_lock_id;
    logic w_lock;

    assign w_lock     = r_gnt ? m1_lock : m0_lock;
    assign w_ptr_hold = r_locked;

    // Lock is sampled in ACK so it takes effect on the very next IDLE.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_locked  <= 1'b0;
            r_lock_id <= 1'b0;
        end else if (r_state == S_ACK) begin
            r_locked  <= w_lock;
            r_lock_id <= r_gnt;
        end
    end
`else
    assign w_ptr_hold = 1'b0;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_req = {m1_req, m0_req};
`ifdef CHECKER_MEM_ARB_LOCK_EN
        if (r_locked) begin
            w_req = r_lock_id ? {m1_req, 1'b0} : {1'b0, m0_req};
        end
`endif
        w_gnt = (w_req == 2'b11) ? r_ptr : w_req[1];
    end

    assign w_we       = w_gnt ? m1_we    : m0_we;
    assign w_sel      = w_gnt ? m1_sel   : m0_sel;
    assign w_adr      = w_gnt ? m1_adr   : m0_adr;
    assign w_dat      = w_gnt ? m1_dat_w : m0_dat_w;
    assign w_sel_low  = lowest_bit(w_sel);
    assign w_mask_low = lowest_bit(r_mask);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= 1'b0;
            r_gnt    <= 1'b0;
            r_mask   <= 4'b0000;
            mem_we   <= 4'b0000;
            mem_adr  <= 16'h0000;
            mem_di   <= 32'h0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_dat_r <= 32'h0;
            m1_dat_r <= 32'h0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|w_req) begin
                        r_gnt   <= w_gnt;
                        if (!w_ptr_hold) begin
                            r_ptr <= ~w_gnt;
                        end
                        mem_adr <= {1'b0, w_adr, 3'b000};
                        mem_di  <= w_dat;
                        if (w_we) begin
                            // First lane strobe is issued in the cycle right after the grant.
                            mem_we  <= w_sel_low;
                            r_mask  <= w_sel & ~w_sel_low;
                            r_state <= S_WRITE;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    if (|r_mask) begin
                        mem_we <= w_mask_low;
                        r_mask <= r_mask & ~w_mask_low;
                    end else begin
                        mem_we  <= 4'b0000;
                        r_state <= S_ACK;
                        if (r_gnt) begin
                            m1_ack <= 1'b1;
                        end else begin
                            m0_ack <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_RWAIT;
                end
                S_RWAIT: begin
                    r_state <= S_ACK;
                    if (r_gnt) begin
                        m1_dat_r <= mem_do;
                        m1_ack   <= 1'b1;
                    end else begin
                        m0_dat_r <= mem_do;
                        m0_ack   <= 1'b1;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_checker_memory_arbiter.sv
// Scoreboard bench for checker_memory_arbiter with a behavioural registered-read byte-lane memory.
`timescale 1ns/1ps
module tb_checker_memory_arbiter;

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] data;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  we = '0;
    logic [1:0]  ack;
    logic [3:0]  sel [2];
    logic [11:0] adr [2];
    logic [31:0] dat_w [2];
    logic [31:0] dat_r [2];
    logic [15:0] mem_adr;
    logic [3:0]  mem_we;
    logic [31:0] mem_di;
    logic [31:0] mem_do;
`ifdef CHECKER_MEM_ARB_LOCK_EN
    logic [1:0]  lock = '0;
`endif

    logic [31:0] mem [512];
    logic [7:0]  ref_mem [2048];
    logic [31:0] last_rd [2];
    exp_t        sb [$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 sys_clk = ~sys_clk;

    checker_memory_arbiter dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
`ifdef CHECKER_MEM_ARB_LOCK_EN
        .m0_lock   (lock[0]),
        .m1_lock   (lock[1]),
`endif
        .m0_req    (req[0]),
        .m0_we     (we[0]),
        .m0_sel    (sel[0]),
        .m0_adr    (adr[0]),
        .m0_dat_w  (dat_w[0]),
        .m0_ack    (ack[0]),
        .m0_dat_r  (dat_r[0]),
        .m1_req    (req[1]),
        .m1_we     (we[1]),
        .m1_sel    (sel[1]),
        .m1_adr    (adr[1]),
        .m1_dat_w  (dat_w[1]),
        .m1_ack    (ack[1]),
        .m1_dat_r  (dat_r[1]),
        .mem_adr   (mem_adr),
        .mem_we    (mem_we),
        .mem_di    (mem_di),
        .mem_do    (mem_do)
    );

    // Registered read (read-before-write), one byte lane per strobe bit.
    always @(posedge sys_clk) begin
        mem_do <= mem[mem_adr[13:5]];
        for (int l = 0; l < 4; l++) begin
            if (mem_we[l]) mem[mem_adr[13:5]][8*l +: 8] = mem_di[8*l +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_word(input logic [11:0] a);
        logic [10:0] b;
        b = {a[10:2], 2'b00};
        return {ref_mem[b | 11'd3], ref_mem[b | 11'd2], ref_mem[b | 11'd1], ref_mem[b]};
    endfunction

    function automatic logic [3:0] exp_strobe(input logic [3:0] s, input int c);
        int k;
        k = 0;
        for (int l = 0; l < 4; l++) begin
            if (s[l]) begin
                k++;
                if (k == c) return 4'(1 << l);
            end
        end
        return 4'b0000;
    endfunction

    task automatic push_exp(input int p, input logic w, input logic [3:0] s,
                            input logic [11:0] a, input logic [31:0] d);
        exp_t e;
        e.port = p;
        e.we   = w;
        e.data = w ? 32'h0 : ref_word(a);
        if (w) begin
            for (int l = 0; l < 4; l++) begin
                if (s[l]) ref_mem[{a[10:2], 2'(l)}] = d[8*l +: 8];
            end
        end
        sb.push_back(e);
    endtask

    // Raise a request, hold it until ack, then drop it for the following IDLE cycle.
    task automatic req_once(input int p, input logic w, input logic [3:0] s,
                            input logic [11:0] a, input logic [31:0] d);
        bit got;
        got = 0;
        we[p] = w; sel[p] = s; adr[p] = a; dat_w[p] = d; req[p] = 1'b1;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge sys_clk);
            if (ack[p]) got = 1;
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        @(posedge sys_clk); #1 req[p] = 1'b0;
        @(posedge sys_clk); #1;
    endtask

    // Single transaction with per-cycle strobe, address and latency checks.
    task automatic do_txn(input int p, input logic w, input logic [3:0] s,
                          input logic [11:0] a, input logic [31:0] d, input int lat);
        bit got;
        got = 0;
        push_exp(p, w, s, a, d);
        we[p] = w; sel[p] = s; adr[p] = a; dat_w[p] = d; req[p] = 1'b1;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge sys_clk);
            check("mem_we", 32'(mem_we), 32'(w ? exp_strobe(s, c) : 4'b0000));
            if (c == 1) begin
                check("mem_adr", 32'(mem_adr), 32'({1'b0, a, 3'b000}));
                if (w) check("mem_di", mem_di, d);
            end
            if (ack[p]) begin
                got = 1;
                check("ack_latency", 32'(c), 32'(lat));
            end
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        @(posedge sys_clk); #1 req[p] = 1'b0;
        @(posedge sys_clk); #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_adr", 32'(mem_adr), 32'd0);
        check("rst_mem_di", mem_di, 32'd0);
        check("rst_m0_ack", 32'(ack[0]), 32'd0);
        check("rst_m1_ack", 32'(ack[1]), 32'd0);
        check("rst_m0_dat_r", dat_r[0], 32'd0);
        check("rst_m1_dat_r", dat_r[1], 32'd0);
    endtask

    task automatic apply_reset();
        sys_rst_n = 1'b0;
        req = '0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        check_reset_outputs();
        sys_rst_n = 1'b1;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        @(posedge sys_clk); #1;
    endtask

    // Scoreboard: every ack pops the next expected response in service order.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            for (int p = 0; p < 2; p++) begin
                if (ack[p]) begin
                    if (sb.size() == 0) begin
                        check("unexpected_ack", 32'(p), 32'hFFFF_FFFF);
                    end else begin
                        mon_e = sb.pop_front();
                        check("ack_port", 32'(p), 32'(mon_e.port));
                        check("dat_r", dat_r[p], mon_e.we ? last_rd[p] : mon_e.data);
                        if (!mon_e.we) last_rd[p] = mon_e.data;
                    end
                    check("other_dat_r", dat_r[1-p], last_rd[1-p]);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            sel[i] = '0; adr[i] = '0; dat_w[i] = '0; last_rd[i] = '0;
        end
        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'(i * 37 + 11);
        ref_mem[16] = 8'h44; ref_mem[17] = 8'h33; ref_mem[18] = 8'h22; ref_mem[19] = 8'h11;
        for (int w = 0; w < 512; w++) begin
            mem[w] = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
        end

        apply_reset();

        do_txn(0, 1'b0, 4'hF,    12'h010, 32'h0,         3);
        do_txn(1, 1'b1, 4'b1011, 12'h020, 32'hAABB_CCDD, 4);
        do_txn(1, 1'b0, 4'hF,    12'h020, 32'h0,         3);
        do_txn(0, 1'b1, 4'b0000, 12'h030, 32'hDEAD_BEEF, 2);
        do_txn(0, 1'b1, 4'b0100, 12'h031, 32'h1234_5678, 2);
        do_txn(0, 1'b0, 4'hF,    12'h030, 32'h0,         3);
        do_txn(1, 1'b1, 4'b1111, 12'h044, 32'h0102_0304, 5);

        // Reset after the second strobe of a full-mask write: only lanes 0 and 1 land.
        ref_mem[12'h040] = 8'h88;
        ref_mem[12'h041] = 8'h77;
        we[0] = 1'b1; sel[0] = 4'hF; adr[0] = 12'h040; dat_w[0] = 32'h5566_7788; req[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge sys_clk);
            check("mid_mem_we", 32'(mem_we), 32'(exp_strobe(4'hF, c)));
        end
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b0;
        req = '0;
        #1 check_reset_outputs();
        repeat (2) @(negedge sys_clk);
        check("mid_no_ack", 32'(ack), 32'd0);
        sys_rst_n = 1'b1;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        @(posedge sys_clk); #1;
        do_txn(1, 1'b0, 4'hF, 12'h040, 32'h0, 3);

        // Continuous contention straight after reset: m0 first, then strict alternation.
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            push_exp(0, 1'b0, 4'hF, 12'h100 + 12'(4*i), 32'h0);
            push_exp(1, 1'b0, 4'hF, 12'h200 + 12'(4*i), 32'h0);
        end
        fork
            for (int i = 0; i < 4; i++) req_once(0, 1'b0, 4'hF, 12'h100 + 12'(4*i), 32'h0);
            for (int j = 0; j < 4; j++) req_once(1, 1'b0, 4'hF, 12'h200 + 12'(4*j), 32'h0);
        join

`ifdef CHECKER_MEM_ARB_LOCK_EN
        // Locked read then unlocked write by m0; m1 waits behind both.
        apply_reset();
        push_exp(0, 1'b0, 4'hF,    12'h010, 32'h0);
        push_exp(0, 1'b1, 4'b0001, 12'h050, 32'h0000_00A5);
        push_exp(1, 1'b0, 4'hF,    12'h060, 32'h0);
        fork
            begin
                lock[0] = 1'b1;
                req_once(0, 1'b0, 4'hF, 12'h010, 32'h0);
                lock[0] = 1'b0;
                req_once(0, 1'b1, 4'b0001, 12'h050, 32'h0000_00A5);
            end
            req_once(1, 1'b0, 4'hF, 12'h060, 32'h0);
        join
`endif

        for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge sys_clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
